pipeline_ctrl: RTL
==================

PIPELINE_CTRL -- requirements
Module: pipeline_ctrl

Interface
REQ-001 Parameter TIMEOUT_LIMIT, default 1024, is the consecutive-stall-cycle count that raises the watchdog flag; legal range 1..65535.
REQ-002 CLK  input  1  single clock; all state updates on the posedge.
REQ-003 RST  input  1  reset; asynchronous and active-high.
REQ-004 ID_STALL_REQ  input  1  ID-stage request, e.g. a load-use hazard.
REQ-005 EX_STALL_REQ  input  1  EX-stage request, e.g. a multi-cycle ALU op busy.
REQ-006 MEM_STALL_REQ  input  1  MEM-stage request, e.g. a data-memory wait.
REQ-007 FLUSH_REQ  input  1  flush request from an exception or redirect.
REQ-008 STALL  output  6  per-stage hold vector; bit 0 PC, 1 IF, 2 ID, 3 EX, 4 MEM, 5 WB; a bit at `STOP holds that stage.
REQ-009 FLUSH  output  1  kills all in-flight pipeline registers this cycle.
REQ-010 STALL_CYCLES  output  32  total cycles with any STALL bit set.
REQ-011 STALL_TIMEOUT  output  1  sticky watchdog flag.

Function
REQ-012 STALL and FLUSH shall be combinational from the request inputs and the current state, so stalls take effect in the request cycle with zero latency.
REQ-013 Request priority shall be FLUSH_REQ > MEM_STALL_REQ > EX_STALL_REQ > ID_STALL_REQ.
REQ-014 STALL encodings shall be:
- MEM request: 6'b011111
- EX request: 6'b001111
- ID request: 6'b000111
- no request: 6'b000000
REQ-015 These encodings shall make the pipeline register downstream of the stalling stage load a bubble, because its upstream bit is at `STOP and its downstream bit is not.
REQ-016 When FLUSH_REQ is high, FLUSH shall be 1 and STALL shall be 6'b000000 regardless of other requests.
REQ-017 The FSM shall have three states: IDLE, HOLD and FLUSHED.
REQ-018 FSM transitions (posedge):
- any state, FLUSH_REQ high -> FLUSHED
- IDLE or HOLD, any stall request effective -> HOLD
- IDLE or HOLD, no effective request -> IDLE
- FLUSHED -> HOLD if MEM or EX request, else IDLE
REQ-019 In FLUSHED, ID_STALL_REQ shall be ignored for STALL generation, because it belongs to a killed instruction; MEM and EX requests shall still be honoured.
REQ-020 A 16-bit hold counter shall increment each cycle STALL is nonzero, saturate at 65535, and clear to 0 in any cycle STALL is zero.
REQ-021 STALL_TIMEOUT shall set on the posedge at which the hold counter reaches TIMEOUT_LIMIT, and shall stay set until reset.
REQ-022 Timeout shall not alter STALL; it is a flag only.
REQ-023 STALL_CYCLES shall increment by 1 each posedge at which STALL was nonzero, and saturate at 32'hFFFFFFFF without wrapping.
REQ-024 All requests deasserting in the same cycle shall give STALL 6'b000000 in that same cycle.
REQ-025 Switching between request types shall update STALL in the same cycle, and the hold counter shall continue counting without clearing.

Reset
REQ-026 While RST is high:
- STALL is forced to 6'b000000 and FLUSH to 0, independent of the inputs
- the state is IDLE
- hold counter, STALL_CYCLES and STALL_TIMEOUT are 0
REQ-027 Reset asserted mid-stall shall clear all state immediately, without waiting for CLK.
REQ-028 The first posedge after RST falls shall evaluate requests normally.

Verification
REQ-029 ID_STALL_REQ for 1 cycle -> STALL=000111 that cycle, then 000000; STALL_CYCLES=1.
REQ-030 MEM_STALL_REQ and EX_STALL_REQ and ID_STALL_REQ together for 3 cycles -> STALL=011111 all 3 cycles; STALL_CYCLES=3; hold counter returns to 0 after.
REQ-031 FLUSH_REQ with ID_STALL_REQ held 2 cycles -> cycle 1: FLUSH=1, STALL=000000; cycle 2 (FLUSHED): FLUSH=0, STALL=000000.
REQ-032 TIMEOUT_LIMIT=4, EX_STALL_REQ held 6 cycles -> STALL_TIMEOUT rises at the 4th posedge, STALL stays 001111, flag holds after release.
REQ-033 RST pulsed asynchronously during a MEM stall -> STALL=000000, STALL_CYCLES=0, STALL_TIMEOUT=0 with no clock edge.
REQ-034 STALL_CYCLES preloaded near saturation by force, stall held -> stays 32'hFFFFFFFF without wrap.

Source files
------------

// File: rtl/pipeline_ctrl.sv
// -----------------------------------------------------------------------------
// pipeline_ctrl
//
// Central stall/flush controller for a six-stage in-order pipeline
// (PC, IF, ID, EX, MEM, WB). Stage requests are prioritised and turned into a
// per-stage hold vector with zero latency. A three-state FSM remembers a flush
// so that a stale ID request from a killed instruction is ignored. A watchdog
// and a statistics counter track the stall behaviour.
//
// Parameters
//   TIMEOUT_LIMIT    consecutive stall cycles that raise o_stall_timeout (1..65535)
//
// Ports
//   i_clk            clock, all state updates on the rising edge
//   i_rst            asynchronous active-high reset
//   i_id_stall_req   ID-stage stall request (e.g. load-use hazard)
//   i_ex_stall_req   EX-stage stall request (e.g. multi-cycle ALU busy)
//   i_mem_stall_req  MEM-stage stall request (e.g. data-memory wait)
//   i_flush_req      flush request (exception / redirect)
//   o_stall[5:0]     per-stage hold vector, bit0 PC .. bit5 WB, 1 = hold
//   o_flush          kill all in-flight pipeline registers this cycle
//   o_stall_cycles   saturating count of cycles with any hold bit set
//   o_stall_timeout  sticky watchdog flag
// -----------------------------------------------------------------------------
module pipeline_ctrl #(
    parameter int unsigned TIMEOUT_LIMIT = 1024
) (
    input  logic        i_clk,
    input  logic        i_rst,
    input  logic        i_id_stall_req,
    input  logic        i_ex_stall_req,
    input  logic        i_mem_stall_req,
    input  logic        i_flush_req,
    output logic [5:0]  o_stall,
    output logic        o_flush,
    output logic [31:0] o_stall_cycles,
    output logic        o_stall_timeout
);

    typedef enum logic [1:0] {
        ST_IDLE    = 2'd0,
        ST_HOLD    = 2'd1,
        ST_FLUSHED = 2'd2
    } state_t;

    // A stalling stage and everything upstream of it hold; the register just
    // downstream of the stalling stage then loads a bubble.
    localparam logic [5:0] STALL_MEM  = 6'b011111;
    localparam logic [5:0] STALL_EX   = 6'b001111;
    localparam logic [5:0] STALL_ID   = 6'b000111;
    localparam logic [5:0] STALL_NONE = 6'b000000;

    localparam logic [15:0] LIMIT = 16'(TIMEOUT_LIMIT);

    state_t      r_state;
    logic [15:0] r_hold_cnt;
    logic [31:0] r_stall_cycles;
    logic        r_stall_timeout;

    logic [5:0]  w_stall;
    logic        w_flush;
    logic        w_id_eff;
    logic        w_stalling;
    logic [15:0] w_hold_inc;

    // After a flush the ID request belongs to a killed instruction.
    assign w_id_eff = i_id_stall_req && (r_state != ST_FLUSHED);

    always_comb begin
        w_stall = STALL_NONE;
        w_flush = 1'b0;
        if (i_rst) begin
            w_stall = STALL_NONE;
            w_flush = 1'b0;
        end else if (i_flush_req) begin
            w_flush = 1'b1;
        end else if (i_mem_stall_req) begin
            w_stall = STALL_MEM;
        end else if (i_ex_stall_req) begin
            w_stall = STALL_EX;
        end else if (w_id_eff) begin
            w_stall = STALL_ID;
        end
    end

    assign w_stalling = (w_stall != STALL_NONE);
    assign w_hold_inc = (r_hold_cnt == 16'hFFFF) ? r_hold_cnt : r_hold_cnt + 16'd1;

    always_ff @(posedge i_clk or posedge i_rst) begin
        if (i_rst) begin
            r_state         <= ST_IDLE;
            r_hold_cnt      <= 16'd0;
            r_stall_cycles  <= 32'd0;
            r_stall_timeout <= 1'b0;
        end else begin
            // State transitions
            if (i_flush_req) begin
                r_state <= ST_FLUSHED;
            end else begin
                case (r_state)
                    ST_FLUSHED: r_state <= (i_mem_stall_req || i_ex_stall_req) ? ST_HOLD : ST_IDLE;
                    ST_IDLE,
                    ST_HOLD:    r_state <= w_stalling ? ST_HOLD : ST_IDLE;
                    default:    r_state <= ST_IDLE;
                endcase
            end

            // Consecutive-stall counter; a switch between request types keeps
            // counting because the hold vector stays nonzero.
            if (w_stalling) begin
                r_hold_cnt <= w_hold_inc;
            end else begin
                r_hold_cnt <= 16'd0;
            end

            // Watchdog flag is raised on the edge where the counter becomes
            // LIMIT and is held until reset.
            if (w_stalling && (w_hold_inc == LIMIT)) begin
                r_stall_timeout <= 1'b1;
            end

            if (w_stalling && (r_stall_cycles != 32'hFFFF_FFFF)) begin
                r_stall_cycles <= r_stall_cycles + 32'd1;
            end
        end
    end

    assign o_stall         = w_stall;
    assign o_flush         = w_flush;
    assign o_stall_cycles  = r_stall_cycles;
    assign o_stall_timeout = r_stall_timeout;

endmodule
